// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the seven-segment scan scheduler.
package display_scan_scheduler_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 3;

    localparam logic [NUM_DIGITS-1:0] MASK_RST   = 8'hFF;
    localparam logic [3:0]            BRIGHT_RST = 4'hF;
    localparam logic [DIGIT_W-1:0]    LAST_DIGIT = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] mask;
        logic [3:0]            bright;
    } scan_cfg_t;

    // Active-low anode pattern with only the selected digit driven.
    function automatic logic [NUM_DIGITS-1:0] anode_select(input logic [DIGIT_W-1:0] idx);
        logic [NUM_DIGITS-1:0] pattern;
        pattern      = '1;
        pattern[idx] = 1'b0;
        return pattern;
    endfunction

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Configuration and display-side signals of the scan scheduler.
interface display_scan_scheduler_if;
    import display_scan_scheduler_pkg::*;

    logic                  enable;
    logic [NUM_DIGITS-1:0] cfg_mask;
    logic [3:0]            cfg_bright;
    logic                  cfg_load;
    logic                  cfg_ack;
    logic [NUM_DIGITS-1:0] anode;
    logic [DIGIT_W-1:0]    seq_sel;
    logic                  frame_start;

    modport master (
        output enable, cfg_mask, cfg_bright, cfg_load,
        input  cfg_ack, anode, seq_sel, frame_start
    );

    modport slave (
        input  enable, cfg_mask, cfg_bright, cfg_load,
        output cfg_ack, anode, seq_sel, frame_start
    );

endinterface

// File: rtl/display_scan_scheduler_next_digit_finder.sv
// Finds the next enabled digit after cur_idx, searching upward and wrapping 7 to 0.
// wrap is set when the found digit is at or below cur_idx; it stays 0 for an empty mask.
module display_scan_scheduler_next_digit_finder
    import display_scan_scheduler_pkg::*;
(
    input  logic [DIGIT_W-1:0]    cur_idx,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic [DIGIT_W-1:0]    next_idx,
    output logic                  wrap
);

    logic [DIGIT_W-1:0] cand;

    // Walk from the farthest offset inward so the nearest enabled digit wins.
    always_comb begin
        next_idx = cur_idx;
        wrap     = 1'b0;
        cand     = cur_idx;
        for (int off = NUM_DIGITS; off >= 1; off--) begin
            cand = cur_idx + DIGIT_W'(off);
            if (mask[cand]) begin
                next_idx = cand;
                wrap     = (cand <= cur_idx);
            end
        end
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Frame-synchronous scan scheduler for the 8-digit seven-segment display:
// dwell timing, digit sequencing, brightness PWM and double-buffered configuration.
module display_scan_scheduler
    import display_scan_scheduler_pkg::*;
#(
    parameter int DWELL_CYCLES = 100000,
    parameter int CNT_W        = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    display_scan_scheduler_if.slave scan_bus
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W+3:0] STEP       = (CNT_W+4)'(DWELL_CYCLES / 16);

    scan_state_t           state;
    scan_state_t           state_next;
    scan_cfg_t             active_cfg;
    scan_cfg_t             shadow_cfg;
    scan_cfg_t             active_next;
    logic                  cfg_pending;
    logic [CNT_W-1:0]      dwell_cnt;
    logic [CNT_W-1:0]      dwell_next;
    logic [DIGIT_W-1:0]    digit;
    logic [DIGIT_W-1:0]    digit_next;
    logic [NUM_DIGITS-1:0] anode_q;
    logic [NUM_DIGITS-1:0] anode_d;
    logic                  frame_start_q;
    logic                  frame_start_d;
    logic                  cfg_ack_q;
    logic                  cfg_ack_d;

    logic [DIGIT_W-1:0]    scan_idx;
    logic                  scan_wrap;
    logic [DIGIT_W-1:0]    entry_idx;
    logic                  entry_found;
    logic                  dwell_end;
    logic                  boundary;
    logic                  apply_cfg;
    logic [CNT_W+3:0]      on_time;
    logic                  pwm_on;

    display_scan_scheduler_next_digit_finder u_scan_finder (
        .cur_idx  (digit),
        .mask     (active_cfg.mask),
        .next_idx (scan_idx),
        .wrap     (scan_wrap)
    );

    // Starting from the last digit yields the lowest enabled digit of the mask
    // that will be active after this edge; its wrap flag doubles as "mask non-empty".
    display_scan_scheduler_next_digit_finder u_entry_finder (
        .cur_idx  (LAST_DIGIT),
        .mask     (active_next.mask),
        .next_idx (entry_idx),
        .wrap     (entry_found)
    );

    assign dwell_end   = (dwell_cnt == DWELL_LAST);
    assign boundary    = (state == SCAN) && scan_bus.enable && dwell_end && scan_wrap;
    // A load landing on the apply cycle supersedes the pending value and waits for the next one.
    assign apply_cfg   = cfg_pending && !scan_bus.cfg_load && ((state == IDLE) || boundary);
    assign active_next = apply_cfg ? shadow_cfg : active_cfg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (scan_bus.enable && (active_cfg.mask != '0) && !cfg_pending) state_next = SCAN;
            SCAN: if (!scan_bus.enable || (boundary && !entry_found)) state_next = IDLE;
        endcase
    end

    always_comb begin
        dwell_next = '0;
        digit_next = digit;
        if (state_next == SCAN) begin
            if (state == IDLE) begin
                digit_next = entry_idx;
            end else if (dwell_end) begin
                digit_next = boundary ? entry_idx : scan_idx;
            end else begin
                dwell_next = dwell_cnt + 1'b1;
            end
        end
    end

    assign on_time = {{CNT_W{1'b0}}, active_next.bright} * STEP;
    assign pwm_on  = (active_next.bright == 4'hF) || ({4'b0000, dwell_next} < on_time);

    always_comb begin
        anode_d       = '1;
        frame_start_d = 1'b0;
        cfg_ack_d     = apply_cfg;
        if (state_next == SCAN) begin
            frame_start_d = (state == IDLE) || boundary;
            if (pwm_on) anode_d = anode_select(digit_next);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_cfg    <= '{mask: MASK_RST, bright: BRIGHT_RST};
            shadow_cfg    <= '{mask: MASK_RST, bright: BRIGHT_RST};
            cfg_pending   <= 1'b0;
            dwell_cnt     <= '0;
            digit         <= '0;
            anode_q       <= '1;
            frame_start_q <= 1'b0;
            cfg_ack_q     <= 1'b0;
        end else begin
            active_cfg    <= active_next;
            if (scan_bus.cfg_load) begin
                shadow_cfg <= '{mask: scan_bus.cfg_mask, bright: scan_bus.cfg_bright};
            end
            cfg_pending   <= scan_bus.cfg_load | (cfg_pending & ~apply_cfg);
            dwell_cnt     <= dwell_next;
            digit         <= digit_next;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
            cfg_ack_q     <= cfg_ack_d;
        end
    end

    assign scan_bus.anode       = anode_q;
    assign scan_bus.seq_sel     = digit;
    assign scan_bus.frame_start = frame_start_q;
    assign scan_bus.cfg_ack     = cfg_ack_q;

endmodule
